mac_dot_sequencer: RTL and testbench
====================================

Name: mac_dot_sequencer

Overview:
- Controller that sequences the shared 8x8 multiply-accumulate datapath through length-N dot products.
- Sits between an operand stream source and the MAC datapath:
  - accepts a start command with a length,
  - clears the accumulator,
  - feeds N operand pairs with valid/ready flow control,
  - waits out datapath latency,
  - presents the final accumulator with a valid/ready result handshake.

Parameters:
- DW, 8: operand width (mac_a, mac_b, in_a, in_b).
- ACCW, 16: accumulator/result width.
- LEN_W, 4: width of the length field; max vector length 2^LEN_W-1.
- MAC_LAT, 1: cycles from mac_en asserted to that product appearing in mac_acc; range 1..3.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global enable; low freezes all state.
- start  in  1  command pulse; sampled only in IDLE.
- len  in  LEN_W  number of operand pairs; captured with start.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer accepts the operand pair this cycle.
- in_a  in  DW  operand A.
- in_b  in  DW  operand B.
- mac_clr  out  1  synchronous accumulator clear to the datapath.
- mac_en  out  1  accumulate mac_a*mac_b this cycle.
- mac_a  out  DW  registered operand A to the datapath.
- mac_b  out  DW  registered operand B to the datapath.
- mac_acc  in  ACCW  datapath accumulator value.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer ready.
- res_data  out  ACCW  captured dot-product result.
- busy  out  1  high in every state except IDLE.
- abort  in  1  abort request; present always, used only with DOT_ABORT_EN.

Behaviour:
- Reset: all outputs 0; state IDLE; counter 0.
- Async assert, synchronous release by flop design.
- ena=0:
  - all registers hold;
  - in_ready=0, mac_en=0, mac_clr=0;
  - res_valid and res_data hold.
- FSM states: IDLE, CLEAR, FEED, DRAIN, RESULT.
- IDLE: on start, capture len into remaining counter and go to CLEAR. start outside IDLE is ignored.
- CLEAR (1 cycle):
  - mac_clr=1.
  - len=0: go to RESULT; res_data captures 0 without reading mac_acc.
  - Otherwise go to FEED.
- FEED:
  - in_ready=1 combinationally while in FEED.
  - On in_valid&&in_ready:
    - register in_a/in_b into mac_a/mac_b;
    - mac_en=1 on the following cycle (registered);
    - decrement remaining.
  - When remaining goes 1->0 on a transfer, go to DRAIN with the drain counter = MAC_LAT.
  - Gaps in in_valid are legal; mac_en stays 0 on gap cycles.
- DRAIN:
  - in_ready=0.
  - Count MAC_LAT cycles after the final mac_en, then capture mac_acc into res_data and go to RESULT.
- RESULT:
  - res_valid=1; res_data stable.
  - On res_ready, go to IDLE; res_valid drops the next cycle.
  - start in the same cycle as the res_ready handshake is ignored; a new start is accepted one cycle later in IDLE.
- Arithmetic:
  - No width growth inside the sequencer; overflow wraps in the datapath.
  - Counter wrap is impossible: it only decrements from a nonzero value.
- Reset mid-operation: immediate return to IDLE; any partial result is discarded.

Optional Feature:
- DOT_ABORT_EN defined:
  - abort=1 in CLEAR/FEED/DRAIN/RESULT forces IDLE next cycle;
  - that cycle also drives mac_clr=1, in_ready=0, res_valid=0;
  - abort in IDLE has no effect;
  - abort and start together in IDLE: start wins.
- DOT_ABORT_EN undefined: the abort input is ignored (no logic).

Decomposition:
- Package mac_seq_pkg:
  - state enum type (IDLE, CLEAR, FEED, DRAIN, RESULT);
  - default widths DW/ACCW/LEN_W;
  - MAC_LAT default constant.
- One natural sub-module: mac_seq_ctr, a loadable down-counter with zero flag, instantiated for both the remaining-pairs and drain counters.

Test Plan:
- Nominal run:
  - Stimulus: reset, start len=3, pairs (3,4), (2,5), (1,10) back-to-back, res_ready=1.
  - Expected: res_data=32, one res_valid pulse, busy low afterwards, mac_clr pulsed once before the first mac_en.
- len=0:
  - Stimulus: start with len=0.
  - Expected: mac_clr pulse, no mac_en, res_valid with res_data=0 two cycles after start.
- Gaps and backpressure:
  - Stimulus: len=2, pairs (255,255) and (255,255) with 3 idle cycles between them; res_ready held 0 for 4 cycles.
  - Expected: res_data=130050 mod 65536=64514, held stable until res_ready.
- ena freeze:
  - Stimulus: drop ena for 5 cycles mid-FEED.
  - Expected: no in_ready, no mac_en, remaining count unchanged; the final result still equals the full dot product.
- Reset mid-DRAIN:
  - Stimulus: assert rst_n=0 asynchronously mid-DRAIN.
  - Expected: outputs 0 immediately, IDLE; the next start len=1, (7,6) gives 42.
- DOT_ABORT_EN build:
  - Stimulus: abort in FEED after 1 of 3 pairs.
  - Expected: IDLE next cycle, mac_clr=1, no res_valid; the next run len=1, (2,3) gives 6.

Source files
------------

// File: rtl/mac_seq_pkg.sv
// Shared types and default sizing for the MAC dot-product sequencer.
package mac_seq_pkg;

  localparam int DEF_DW      = 8;
  localparam int DEF_ACCW    = 16;
  localparam int DEF_LEN_W   = 4;
  localparam int DEF_MAC_LAT = 1;
  // Wide enough for the largest supported datapath latency (3).
  localparam int DRAIN_W     = 2;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FEED   = 3'd2,
    S_DRAIN  = 3'd3,
    S_RESULT = 3'd4
  } seq_state_e;

endpackage

// File: rtl/mac_dot_sequencer_if.sv
// Command, operand stream, MAC datapath and result signals of the dot-product sequencer.
// The master modport is the surrounding system; the slave modport is the sequencer.
interface mac_dot_sequencer_if
  import mac_seq_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int ACCW  = DEF_ACCW,
  parameter int LEN_W = DEF_LEN_W
);

  logic             ena;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    in_a;
  logic [DW-1:0]    in_b;
  logic             mac_clr;
  logic             mac_en;
  logic [DW-1:0]    mac_a;
  logic [DW-1:0]    mac_b;
  logic [ACCW-1:0]  mac_acc;
  logic             res_valid;
  logic             res_ready;
  logic [ACCW-1:0]  res_data;
  logic             busy;
  logic             abort;

  modport master (
    output ena, start, len, in_valid, in_a, in_b, mac_acc, res_ready, abort,
    input  in_ready, mac_clr, mac_en, mac_a, mac_b, res_valid, res_data, busy
  );

  modport slave (
    input  ena, start, len, in_valid, in_a, in_b, mac_acc, res_ready, abort,
    output in_ready, mac_clr, mac_en, mac_a, mac_b, res_valid, res_data, busy
  );

endinterface

// File: rtl/mac_seq_ctr.sv
// Loadable down-counter with zero flag; load has priority and it never wraps below zero.
module mac_seq_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic [W-1:0] count_o,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: cnt_d gets its hold value first so every path assigns it and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // NOTE: state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign zero_o  = (cnt_q == '0);

endmodule

// File: rtl/mac_dot_sequencer.sv
// Sequences a shared MAC datapath through length-N dot products with valid/ready on both ends.
// Define DOT_ABORT_EN to enable the abort input; otherwise abort is ignored.
module mac_dot_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int ACCW    = DEF_ACCW,
  parameter int LEN_W   = DEF_LEN_W,
  parameter int MAC_LAT = DEF_MAC_LAT
) (
  input logic                clk,
  input logic                rst_n,
  mac_dot_sequencer_if.slave bus
);

  seq_state_e          state_q, state_d;
  logic [DW-1:0]       mac_a_q, mac_a_d;
  logic [DW-1:0]       mac_b_q, mac_b_d;
  logic                mac_en_q, mac_en_d;
  logic [ACCW-1:0]     res_data_q, res_data_d;

  logic [LEN_W-1:0]    rem_cnt;
  logic                rem_zero, rem_load, rem_dec;
  logic [DRAIN_W-1:0]  unused_drn_cnt;
  logic                drn_zero, drn_load, drn_dec;

  logic                abort_hit;
  logic                in_ready;
  logic                mac_clr;
  logic                res_valid;

`ifdef DOT_ABORT_EN
  assign abort_hit = bus.abort && bus.ena && (state_q != S_IDLE);
`else
  logic unused_abort;
  assign unused_abort = bus.abort;
  assign abort_hit    = 1'b0;
`endif

  mac_seq_ctr #(.W(LEN_W)) u_rem_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (rem_load),
    .dec_i      (rem_dec),
    .load_val_i (bus.len),
    .count_o    (rem_cnt),
    .zero_o     (rem_zero)
  );

  mac_seq_ctr #(.W(DRAIN_W)) u_drn_ctr (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (drn_load),
    .dec_i      (drn_dec),
    .load_val_i (DRAIN_W'(MAC_LAT)),
    .count_o    (unused_drn_cnt),
    .zero_o     (drn_zero)
  );

  always_comb begin
    state_d    = state_q;
    mac_a_d    = mac_a_q;
    mac_b_d    = mac_b_q;
    mac_en_d   = mac_en_q;
    res_data_d = res_data_q;
    rem_load   = 1'b0;
    rem_dec    = 1'b0;
    drn_load   = 1'b0;
    drn_dec    = 1'b0;
    in_ready   = 1'b0;
    mac_clr    = 1'b0;
    res_valid  = (state_q == S_RESULT);

    // With ena low every register holds and the strobes stay at their idle values.
    if (bus.ena) begin
      mac_en_d = 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            rem_load = 1'b1;
            state_d  = S_CLEAR;
          end
        end
        S_CLEAR: begin
          mac_clr = 1'b1;
          if (rem_zero) begin
            res_data_d = '0;
            state_d    = S_RESULT;
          end else begin
            state_d = S_FEED;
          end
        end
        S_FEED: begin
          in_ready = 1'b1;
          if (bus.in_valid) begin
            mac_a_d  = bus.in_a;
            mac_b_d  = bus.in_b;
            mac_en_d = 1'b1;
            rem_dec  = 1'b1;
            if (rem_cnt == LEN_W'(1)) begin
              drn_load = 1'b1;
              state_d  = S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          // The drain count reaches zero exactly when the last product is in mac_acc.
          if (drn_zero) begin
            res_data_d = bus.mac_acc;
            state_d    = S_RESULT;
          end else begin
            drn_dec = 1'b1;
          end
        end
        S_RESULT: begin
          if (bus.res_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (abort_hit) begin
        state_d    = S_IDLE;
        mac_clr    = 1'b1;
        in_ready   = 1'b0;
        res_valid  = 1'b0;
        mac_en_d   = 1'b0;
        res_data_d = res_data_q;
        rem_dec    = 1'b0;
        drn_load   = 1'b0;
        drn_dec    = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      mac_a_q    <= '0;
      mac_b_q    <= '0;
      mac_en_q   <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mac_a_q    <= mac_a_d;
      mac_b_q    <= mac_b_d;
      mac_en_q   <= mac_en_d;
      res_data_q <= res_data_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mac_clr   = mac_clr;
  assign bus.mac_en    = mac_en_q && bus.ena && !abort_hit;
  assign bus.mac_a     = mac_a_q;
  assign bus.mac_b     = mac_b_q;
  assign bus.res_valid = res_valid;
  assign bus.res_data  = res_data_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Self-checking bench for mac_dot_sequencer: vector table plus directed multi-cycle sequences,
// with a one-cycle-latency accumulator standing in for the MAC datapath.
module tb_mac_dot_sequencer;
  import mac_seq_pkg::*;

  localparam int MAC_LAT = 1;
  localparam int NV      = 10;

  typedef struct {
    int               n;
    logic [14:0][7:0] a;
    logic [14:0][7:0] b;
    int               gap;
    int               hold;
    int               frz;
    logic [15:0]      exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_dot_sequencer_if #(.DW(8), .ACCW(16), .LEN_W(4)) bus ();

  mac_dot_sequencer #(.DW(8), .ACCW(16), .LEN_W(4), .MAC_LAT(MAC_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           bus.mac_acc <= '0;
    else if (bus.mac_clr) bus.mac_acc <= '0;
    else if (bus.mac_en)  bus.mac_acc <= bus.mac_acc + 16'(bus.mac_a) * 16'(bus.mac_b);
  end

  int n_checks = 0;
  int n_errors = 0;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_dot(input vec_t v);
    int sum = 0;
    for (int i = 0; i < v.n; i++) sum += int'(v.a[i]) * int'(v.b[i]);
    return 16'(sum);
  endfunction

  function automatic vec_t mk(input int n, input int gap, input int hold, input int frz,
                              input logic [15:0] exp);
    vec_t v;
    v.n = n; v.a = '0; v.b = '0; v.gap = gap; v.hold = hold; v.frz = frz; v.exp = exp;
    return v;
  endfunction

  task automatic run_dot(input vec_t v, input string name);
    int idx = 0, gap_left = 0, clr_cnt = 0, en_cnt = 0, frz_left = 5, cyc = 0;
    bit order_ok = 1'b1, frz_ok = 1'b1, hold_ok = 1'b1, seen = 1'b0, frozen;
    int exp_lat;
    @(negedge clk); bus.start = 1'b1; bus.len = 4'(v.n);
    @(negedge clk); bus.start = 1'b0;
    for (cyc = 0; cyc < 300; cyc++) begin
      frozen  = (v.frz >= 0) && (idx == v.frz) && (frz_left > 0);
      bus.ena = !frozen;
      if (idx < v.n && gap_left == 0) begin
        bus.in_valid = 1'b1; bus.in_a = v.a[idx]; bus.in_b = v.b[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.mac_clr) clr_cnt++;
      if (bus.mac_en) begin
        en_cnt++;
        if (clr_cnt == 0) order_ok = 1'b0;
      end
      if (frozen) begin
        if (bus.in_ready || bus.mac_en || bus.mac_clr) frz_ok = 1'b0;
        frz_left--;
      end else if (bus.in_valid && bus.in_ready) begin
        idx++; gap_left = v.gap;
      end else if (gap_left > 0) begin
        gap_left--;
      end
      if (bus.res_valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    bus.ena = 1'b1; bus.in_valid = 1'b0;
    check({name, ".res_valid_seen"}, 32'(seen), 32'd1);
    if (!seen) return;
    check({name, ".res_data"}, 32'(bus.res_data), 32'(v.exp));
    check({name, ".clr_pulses"}, 32'(clr_cnt), 32'd1);
    check({name, ".mac_en_pulses"}, 32'(en_cnt), 32'(v.n));
    check({name, ".clr_before_en"}, 32'(order_ok), 32'd1);
    if (v.frz >= 0) check({name, ".freeze_quiet"}, 32'(frz_ok), 32'd1);
    if (v.gap == 0 && v.frz < 0) begin
      exp_lat = (v.n == 0) ? 1 : v.n + MAC_LAT + 2;
      check({name, ".latency"}, 32'(cyc), 32'(exp_lat));
    end
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk); bus.res_ready = 1'b0; bus.start = 1'b1; bus.len = 4'd5;
      #1;
      if (!(bus.res_valid && bus.busy && bus.res_data == v.exp)) hold_ok = 1'b0;
    end
    if (v.hold > 0) check({name, ".hold_stable"}, 32'(hold_ok), 32'd1);
    @(negedge clk); bus.start = 1'b0; bus.res_ready = 1'b1;
    #1; check({name, ".res_valid_at_handshake"}, 32'(bus.res_valid), 32'd1);
    @(negedge clk); bus.res_ready = 1'b0;
    #1;
    check({name, ".res_valid_drop"}, 32'(bus.res_valid), 32'd0);
    check({name, ".busy_after"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the end of the test");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bus.ena = 1'b1; bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b0; bus.abort = 1'b0;

    vecs[0] = mk(3, 0, 0, -1, 16'd32);
    vecs[0].a[0] = 8'd3; vecs[0].b[0] = 8'd4;
    vecs[0].a[1] = 8'd2; vecs[0].b[1] = 8'd5;
    vecs[0].a[2] = 8'd1; vecs[0].b[2] = 8'd10;
    vecs[1] = mk(0, 0, 0, -1, 16'd0);
    vecs[2] = mk(2, 3, 4, -1, 16'd64514);
    vecs[2].a[0] = 8'd255; vecs[2].b[0] = 8'd255;
    vecs[2].a[1] = 8'd255; vecs[2].b[1] = 8'd255;
    vecs[3] = mk(3, 0, 0, 1, 16'd44);
    vecs[3].a[0] = 8'd1; vecs[3].b[0] = 8'd2;
    vecs[3].a[1] = 8'd3; vecs[3].b[1] = 8'd4;
    vecs[3].a[2] = 8'd5; vecs[3].b[2] = 8'd6;
    vecs[4] = mk(15, 0, 1, -1, 16'd30600);
    for (int k = 0; k < 15; k++) begin
      vecs[4].a[k] = 8'(k + 1); vecs[4].b[k] = 8'd255;
    end
    for (int i = 5; i < NV; i++) begin
      vecs[i] = mk(int'($urandom_range(1, 15)), int'($urandom_range(0, 2)),
                   int'($urandom_range(0, 3)), -1, 16'd0);
      for (int k = 0; k < vecs[i].n; k++) begin
        vecs[i].a[k] = 8'($urandom_range(0, 255));
        vecs[i].b[k] = 8'($urandom_range(0, 255));
      end
      vecs[i].exp = ref_dot(vecs[i]);
    end

    repeat (2) @(negedge clk);
    #1;
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.in_ready", 32'(bus.in_ready), 32'd0);
    check("reset.mac_clr", 32'(bus.mac_clr), 32'd0);
    check("reset.mac_en", 32'(bus.mac_en), 32'd0);
    check("reset.mac_a", 32'(bus.mac_a), 32'd0);
    check("reset.mac_b", 32'(bus.mac_b), 32'd0);
    check("reset.res_valid", 32'(bus.res_valid), 32'd0);
    check("reset.res_data", 32'(bus.res_data), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < NV; i++) run_dot(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset while draining the last product.
    @(negedge clk); bus.start = 1'b1; bus.len = 4'd2;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.in_valid = 1'b1; bus.in_a = 8'd9; bus.in_b = 8'd9;
    @(negedge clk); bus.in_a = 8'd8; bus.in_b = 8'd8;
    @(negedge clk); bus.in_valid = 1'b0;
    #1;
    check("drain.busy", 32'(bus.busy), 32'd1);
    check("drain.mac_en", 32'(bus.mac_en), 32'd1);
    #1; rst_n = 1'b0;
    #1;
    check("rst_mid.busy", 32'(bus.busy), 32'd0);
    check("rst_mid.mac_en", 32'(bus.mac_en), 32'd0);
    check("rst_mid.mac_a", 32'(bus.mac_a), 32'd0);
    check("rst_mid.res_data", 32'(bus.res_data), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    v = mk(1, 0, 0, -1, 16'd42); v.a[0] = 8'd7; v.b[0] = 8'd6;
    run_dot(v, "after_reset");

    // start coinciding with the result handshake is ignored, accepted one cycle later.
    @(negedge clk); bus.start = 1'b1; bus.len = 4'd0;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.res_ready = 1'b1; bus.start = 1'b1;
    #1;
    check("hs_start.res_valid", 32'(bus.res_valid), 32'd1);
    check("hs_start.res_data", 32'(bus.res_data), 32'd0);
    @(negedge clk); bus.res_ready = 1'b0;
    #1;
    check("hs_start.ignored_busy", 32'(bus.busy), 32'd0);
    @(negedge clk); bus.start = 1'b0;
    #1;
    check("hs_start.accepted_busy", 32'(bus.busy), 32'd1);
    check("hs_start.accepted_clr", 32'(bus.mac_clr), 32'd1);
    @(negedge clk); bus.res_ready = 1'b1;
    #1; check("hs_start.second_result", 32'(bus.res_valid), 32'd1);
    @(negedge clk); bus.res_ready = 1'b0;
    #1; check("hs_start.idle", 32'(bus.busy), 32'd0);

`ifdef DOT_ABORT_EN
    @(negedge clk); bus.start = 1'b1; bus.len = 4'd3;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.in_valid = 1'b1; bus.in_a = 8'd50; bus.in_b = 8'd50;
    @(negedge clk); bus.in_a = 8'd1; bus.in_b = 8'd1; bus.abort = 1'b1;
    #1;
    check("abort.mac_clr", 32'(bus.mac_clr), 32'd1);
    check("abort.in_ready", 32'(bus.in_ready), 32'd0);
    check("abort.res_valid", 32'(bus.res_valid), 32'd0);
    @(negedge clk); bus.abort = 1'b0; bus.in_valid = 1'b0;
    #1;
    check("abort.idle", 32'(bus.busy), 32'd0);
    check("abort.no_mac_en", 32'(bus.mac_en), 32'd0);
    @(negedge clk); bus.abort = 1'b1; bus.start = 1'b1; bus.len = 4'd1;
    #1; check("abort_idle.no_clr", 32'(bus.mac_clr), 32'd0);
    @(negedge clk); bus.abort = 1'b0; bus.start = 1'b0;
    #1; check("abort_start.start_wins", 32'(bus.busy), 32'd1);
    @(negedge clk); bus.abort = 1'b1;
    @(negedge clk); bus.abort = 1'b0;
    #1; check("abort_start.idle", 32'(bus.busy), 32'd0);
    v = mk(1, 0, 0, -1, 16'd6); v.a[0] = 8'd2; v.b[0] = 8'd3;
    run_dot(v, "after_abort");
`else
    bus.abort = 1'b1;
    v = mk(2, 0, 0, -1, 16'd500);
    v.a[0] = 8'd10; v.b[0] = 8'd10; v.a[1] = 8'd20; v.b[1] = 8'd20;
    run_dot(v, "abort_ignored");
    bus.abort = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
